// File: rtl/burst_cmd_sequencer_if.sv
// Bundle of command, write-stream, read-return and memory-path signals
// for burst_cmd_sequencer. slave = sequencer side, master = environment.
interface burst_cmd_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 4
);
    // command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    // write-data stream
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wdata_valid;
    logic                  wdata_ready;
    // read return and completion
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_valid;
    logic                  done;
    // memory path
    logic                  burst_en;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic                  wren;
    logic                  rden;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wdata, wdata_valid, mem_rd_data,
        output cmd_ready, wdata_ready, rdata, rdata_valid, done,
        output burst_en, addr_out, wren, rden, wr_data
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wdata, wdata_valid, mem_rd_data,
        input  cmd_ready, wdata_ready, rdata, rdata_valid, done,
        input  burst_en, addr_out, wren, rden, wr_data
    );
endinterface

// File: rtl/burst_cmd_sequencer.sv
// Expands one burst command at a time into per-beat SRAM strobes.
// Ports: clk, rstn (sync, active-low), bus (slave modport of the if).
module burst_cmd_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 4,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    burst_cmd_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } state_t;

    state_t                state_q;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] base_nx;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  len_nx;
    logic [LEN_WIDTH-1:0]  beat_q;
    logic [LEN_WIDTH-1:0]  beat_nx;

    logic                  cmd_ready_q;
    logic                  cmd_ready_nx;
    logic                  wdata_ready_q;
    logic                  wdata_ready_nx;
    logic                  burst_en_q;
    logic                  burst_en_nx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic                  wren_q;
    logic                  wren_nx;
    logic                  rden_q;
    logic                  rden_nx;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [DATA_WIDTH-1:0] wr_data_nx;
    logic                  done_wr_q;
    logic                  done_wr_nx;

    logic [RD_LAT-1:0]     vpipe_q;
    logic [RD_LAT-1:0]     vpipe_nx;
    logic [DATA_WIDTH-1:0] rhold_q;

    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic                  ret_valid;
    logic                  pipe_busy;
    logic                  rd_last;

    assign last_beat = (beat_q == len_q);
    assign beat_addr = base_q + ADDR_WIDTH'(beat_q);
    assign ret_valid = vpipe_q[RD_LAT-1];

    // The returning beat is the last one when nothing else is still
    // in flight: no rden this cycle and no younger pipe stage set.
    always_comb begin
        pipe_busy = rden_q;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            pipe_busy = pipe_busy | vpipe_q[i];
        end
        rd_last = (state_q == DRAIN) && ret_valid && !pipe_busy;
    end

    // Valid shift pipe; stage 0 follows the registered rden strobe.
    always_comb begin
        vpipe_nx    = '0;
        vpipe_nx[0] = rden_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vpipe_nx[i] = vpipe_q[i-1];
        end
    end

    always_comb begin
        state_nx    = state_q;
        base_nx     = base_q;
        len_nx      = len_q;
        beat_nx     = beat_q;
        burst_en_nx = 1'b0;
        addr_nx     = addr_q;
        wren_nx     = 1'b0;
        rden_nx     = 1'b0;
        wr_data_nx  = wr_data_q;
        done_wr_nx  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    base_nx  = bus.cmd_addr;
                    len_nx   = bus.cmd_len;
                    beat_nx  = '0;
                    state_nx = bus.cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (bus.wdata_valid && wdata_ready_q) begin
                    wren_nx     = 1'b1;
                    wr_data_nx  = bus.wdata;
                    addr_nx     = beat_addr;
                    burst_en_nx = (beat_q != '0);
                    beat_nx     = beat_q + 1'b1;
                    if (last_beat) begin
                        state_nx   = IDLE;
                        done_wr_nx = 1'b1;
                    end
                end
            end
            READ: begin
                rden_nx     = 1'b1;
                addr_nx     = beat_addr;
                burst_en_nx = (beat_q != '0);
                beat_nx     = beat_q + 1'b1;
                if (last_beat) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_last) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Hold off a new command during the write done cycle so the
        // next acceptance is always the cycle after done.
        cmd_ready_nx   = (state_nx == IDLE) && !done_wr_nx;
        wdata_ready_nx = (state_nx == WRITE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            base_q        <= '0;
            len_q         <= '0;
            beat_q        <= '0;
            cmd_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            burst_en_q    <= 1'b0;
            addr_q        <= '0;
            wren_q        <= 1'b0;
            rden_q        <= 1'b0;
            wr_data_q     <= '0;
            done_wr_q     <= 1'b0;
            vpipe_q       <= '0;
            rhold_q       <= '0;
        end else begin
            state_q       <= state_nx;
            base_q        <= base_nx;
            len_q         <= len_nx;
            beat_q        <= beat_nx;
            cmd_ready_q   <= cmd_ready_nx;
            wdata_ready_q <= wdata_ready_nx;
            burst_en_q    <= burst_en_nx;
            addr_q        <= addr_nx;
            wren_q        <= wren_nx;
            rden_q        <= rden_nx;
            wr_data_q     <= wr_data_nx;
            done_wr_q     <= done_wr_nx;
            vpipe_q       <= vpipe_nx;
            if (ret_valid) begin
                rhold_q <= bus.mem_rd_data;
            end
        end
    end

    // rdata passes the memory data through on a return cycle and
    // otherwise holds the last returned beat.
    assign bus.rdata       = ret_valid ? bus.mem_rd_data : rhold_q;
    assign bus.rdata_valid = ret_valid;
    assign bus.done        = done_wr_q | rd_last;
    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.wdata_ready = wdata_ready_q;
    assign bus.burst_en    = burst_en_q;
    assign bus.addr_out    = addr_q;
    assign bus.wren        = wren_q;
    assign bus.rden        = rden_q;
    assign bus.wr_data     = wr_data_q;

endmodule
